mem_arbiter_16: RTL and testbench
=================================

# mem_arbiter_16

Arbiter and access sequencer for the shared 4096 x 16 RAM (`ram_16bit`). It replaces the static `sel_in` mux between the CPU (`yildiz_cpu_16bit`) and the external host/loader port. Each requester has its own request/acknowledge handshake. Conflicts are resolved round-robin, and the host can lock out the CPU for program loading. The block sits between the two requesters and the RAM. It owns `ram_we`, `ram_addr` and `ram_din`, and it captures read data from `ram_dout`.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 12, RAM address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_adr  in  ADDR_WIDTH  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data; valid with cpu_ack, held until next CPU read completes
- host_req, host_we, host_adr, host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  host port, same rules as CPU
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_WIDTH  host read data, same rules as cpu_rdata
- host_lock  in  1  1 = CPU excluded from arbitration
- cpu_hold  out  1  equals host_lock (combinational); CPU sequencer freezes on it
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, registered in RAM (1-cycle latency)
- busy  out  1  1 when state is not IDLE
- owner  out  1  0 = CPU, 1 = host; current or last granted port
- conflict_cnt  out  8  saturating count of cycles with both ports eligible in IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and CAPTURE. IDLE -> ACCESS only on a grant. ACCESS -> CAPTURE unconditionally. CAPTURE -> IDLE unconditionally.
- Eligibility in IDLE:
  - CPU is eligible when cpu_req & ~cpu_ack & ~host_lock.
  - Host is eligible when host_req & ~host_ack.
  - A port whose ack is high this cycle is ignored, because its req may still be high.
- Grant:
  - If only one port is eligible, it wins.
  - If both are eligible, the port that was not last_owner wins, and conflict_cnt increments, saturating at 255.
- On grant, the edge latches owner, we, adr and wdata from the winner into internal registers and updates last_owner.
- ACCESS drives ram_addr = latched adr and ram_din = latched wdata. ram_we = latched we, and it is high for exactly this one cycle.
- CAPTURE keeps ram_addr held and ram_we = 0. At the end of this cycle:
  - The owner's ack register is set.
  - For reads, the owner's rdata register loads ram_dout.
  - For writes, the rdata register is unchanged.
- The ack registers clear automatically after one cycle.
- In IDLE, ram_we = 0 and ram_addr/ram_din hold their last latched values.
- host_lock rising during a CPU transaction does not abort it; the transaction completes. The lock only affects later arbitration.
- Address arithmetic is none: the address passes through unchanged, so 0xFFF is a legal address with no wrap logic.

## Timing
- Reset (rst = 0, asynchronous):
  - State = IDLE and all latched registers = 0.
  - cpu_ack = host_ack = 0 and cpu_rdata = host_rdata = 0.
  - ram_we = 0 immediately, including mid-ACCESS, so an aborted write is not performed.
  - owner = 0, busy = 0, conflict_cnt = 0, last_owner = host (the CPU wins the first conflict).
  - In-flight requests are discarded. Requesters holding req are re-arbitrated after rst rises.
- Latency: req sampled high at IDLE edge E0 -> ACCESS in cycle E0+1 -> CAPTURE in cycle E0+2 -> ack high in cycle E0+3. That is 3 cycles from sampling to ack.
- Throughput: one access per 3 cycles. Back-to-back grants are possible: the other port can be granted in the IDLE cycle in which the first port's ack is high.
- Handshake: a requester deasserts req, or presents a new request, no earlier than the cycle after ack. Changing we/adr/wdata while req is high and before ack is illegal; the latched values are used regardless.
- ram_we, ram_addr and ram_din are decoded only from registered state, with no combinational path from req inputs to RAM.

## Test plan
- Reset mid-write: assert rst = 0 during ACCESS of a host write to 0x020 -> ram_we falls at once; after release, a read of 0x020 returns the prior value; all acks 0 and conflict_cnt = 0.
- CPU write 0x1234 @ 0x010, then CPU read 0x010 -> each cpu_ack arrives 3 cycles after sampling, ram_we high for exactly 1 cycle, cpu_rdata = 0x1234.
- Both ports request in the same IDLE cycle after reset (host write 0xBEEF @ 0x100, CPU read 0x100) -> CPU served first and returns the old data; host_ack arrives 3 cycles after cpu_ack; conflict_cnt = 1.
- Both ports hold continuous back-to-back requests for 6 transactions -> owner alternates CPU, host, CPU, …; no port is served twice in a row.
- host_lock = 1 while cpu_req is held: host writes 0xABCD @ 0xFFF and reads it back -> cpu_hold = 1, CPU never granted, host_rdata = 0xABCD; lock drops -> CPU granted at the next IDLE.
- 300 forced conflicts -> conflict_cnt stops at 255 and does not wrap.

Source files
------------

// File: rtl/mem_arbiter_16.sv
// Round-robin arbiter and access sequencer for the shared 4096x16 RAM.
// CPU and host each own a req/ack handshake; host_lock excludes the CPU from arbitration.
module mem_arbiter_16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_adr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  host_lock,
  output logic                  cpu_hold,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  owner,
  output logic [7:0]            conflict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_last_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ram_we;
  logic                  r_cpu_ack;
  logic                  r_host_ack;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic [7:0]            r_conflict_cnt;

  logic                  w_cpu_elig;
  logic                  w_host_elig;
  logic                  w_conflict;
  logic                  w_grant;
  logic                  w_winner;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_adr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  // A port whose ack is high this cycle may still hold req, so it is not eligible.
  always_comb begin
    w_cpu_elig  = cpu_req & ~r_cpu_ack & ~host_lock;
    w_host_elig = host_req & ~r_host_ack;
    w_conflict  = w_cpu_elig & w_host_elig;
    w_grant     = w_cpu_elig | w_host_elig;
    w_winner    = w_conflict ? ~r_last_owner : w_host_elig;
    w_win_we    = (w_winner == OWN_HOST) ? host_we    : cpu_we;
    w_win_adr   = (w_winner == OWN_HOST) ? host_adr   : cpu_adr;
    w_win_wdata = (w_winner == OWN_HOST) ? host_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_CPU;
      r_last_owner   <= OWN_HOST;
      r_we           <= 1'b0;
      r_adr          <= '0;
      r_wdata        <= '0;
      r_ram_we       <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_host_ack     <= 1'b0;
      r_cpu_rdata    <= '0;
      r_host_rdata   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_conflict && (r_conflict_cnt != 8'hFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
          end
          if (w_grant) begin
            r_state      <= S_ACCESS;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_we         <= w_win_we;
            r_adr        <= w_win_adr;
            r_wdata      <= w_win_wdata;
            r_ram_we     <= w_win_we;
          end
        end
        S_ACCESS: begin
          r_state  <= S_CAPTURE;
          r_ram_we <= 1'b0;
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
          if (r_owner == OWN_HOST) begin
            r_host_ack <= 1'b1;
            if (!r_we) begin
              r_host_rdata <= ram_dout;
            end
          end else begin
            r_cpu_ack <= 1'b1;
            if (!r_we) begin
              r_cpu_rdata <= ram_dout;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack      = r_cpu_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign host_ack     = r_host_ack;
  assign host_rdata   = r_host_rdata;
  assign cpu_hold     = host_lock;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_adr;
  assign ram_din      = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign owner        = r_owner;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter_16.sv
// Scoreboard bench for mem_arbiter_16 with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_adr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_adr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_lock = 1'b0;
  logic        cpu_hold;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        busy;
  logic        owner;
  logic [7:0]  conflict_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cycles = 0;
  int model_cnt = 0;

  logic [15:0] ram [0:4095];
  logic [15:0] cpu_exp_q[$];
  logic [15:0] host_exp_q[$];
  logic        exp_order_q[$];
  logic        ack_log[$];
  int          ack_cyc_log[$];

  mem_arbiter_16 #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .host_lock(host_lock), .cpu_hold(cpu_hold),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ram_we) we_cycles = we_cycles + 1;
    if (cpu_ack) begin ack_log.push_back(1'b0); ack_cyc_log.push_back(cyc); end
    if (host_ack) begin ack_log.push_back(1'b1); ack_cyc_log.push_back(cyc); end
  end

  task automatic cpu_txn(input logic we, input logic [11:0] adr, input logic [15:0] wd,
                         output logic [15:0] rd, output int ack_at, output int lat, output bit tmo);
    int t0;
    t0 = cyc; tmo = 1'b1; ack_at = -1; lat = -1; rd = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cpu_ack) begin
        tmo = 1'b0; ack_at = cyc; lat = cyc - t0; rd = cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic host_txn(input logic we, input logic [11:0] adr, input logic [15:0] wd,
                          output logic [15:0] rd, output int ack_at, output int lat, output bit tmo);
    int t0;
    t0 = cyc; tmo = 1'b1; ack_at = -1; lat = -1; rd = '0;
    host_req = 1'b1; host_we = we; host_adr = adr; host_wdata = wd;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (host_ack) begin
        tmo = 1'b0; ack_at = cyc; lat = cyc - t0; rd = host_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({cpu_ack, host_ack, ram_we, busy, owner} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got ack=%b/%b we=%b busy=%b owner=%b exp all 0",
               cpu_ack, host_ack, ram_we, busy, owner);
    end
    checks++;
    if (cpu_rdata !== 16'h0 || host_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h exp 0000/0000", cpu_rdata, host_rdata);
    end
    checks++;
    if (conflict_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d exp 0", conflict_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] rd, e;
    int at, lat;
    bit tmo;
    host_exp_q.push_back(16'h0000);
    host_txn(1'b1, 12'h020, 16'h5A5A, rd, at, lat, tmo);
    e = host_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e) begin
      failures++;
      $display("FAIL prewrite: got rdata=%h tmo=%0d exp %h", rd, tmo, e);
    end
    host_req = 1'b1; host_we = 1'b1; host_adr = 12'h020; host_wdata = 16'hDEAD;
    @(posedge clk); #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'h020 || busy !== 1'b1) begin
      failures++;
      $display("FAIL access_drive: got we=%b addr=%h busy=%b exp 1/020/1", ram_we, ram_addr, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_we: got we=%b busy=%b exp 0/0", ram_we, busy);
    end
    checks++;
    if (host_ack !== 1'b0 || cpu_ack !== 1'b0 || conflict_cnt !== 8'd0 || host_rdata !== 16'h0) begin
      failures++;
      $display("FAIL abort_state: got acks=%b%b cnt=%0d hrd=%h exp 00/0/0000",
               cpu_ack, host_ack, conflict_cnt, host_rdata);
    end
    host_req = 1'b0; host_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    host_exp_q.push_back(16'h5A5A);
    host_txn(1'b0, 12'h020, 16'h0, rd, at, lat, tmo);
    e = host_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e) begin
      failures++;
      $display("FAIL abort_readback: got %h tmo=%0d exp %h", rd, tmo, e);
    end
  endtask

  task automatic test_conflict();
    logic [15:0] crd, hrd, e;
    int cat, clat, hat, hlat;
    bit ctmo, htmo;
    host_exp_q.push_back(16'h5A5A);
    host_txn(1'b1, 12'h100, 16'h1111, hrd, hat, hlat, htmo);
    e = host_exp_q.pop_front();
    checks++;
    if (htmo || hrd !== e) begin
      failures++;
      $display("FAIL conf_pre: got %h tmo=%0d exp %h", hrd, htmo, e);
    end
    cpu_exp_q.push_back(16'h1111);
    host_exp_q.push_back(16'h5A5A);
    fork
      cpu_txn(1'b0, 12'h100, 16'h0, crd, cat, clat, ctmo);
      host_txn(1'b1, 12'h100, 16'hBEEF, hrd, hat, hlat, htmo);
    join
    model_cnt = model_cnt + 1;
    e = cpu_exp_q.pop_front();
    checks++;
    if (ctmo || crd !== e || clat !== 3) begin
      failures++;
      $display("FAIL conf_cpu_first: got rdata=%h lat=%0d tmo=%0d exp %h lat 3", crd, clat, ctmo, e);
    end
    e = host_exp_q.pop_front();
    checks++;
    if (htmo || hrd !== e || (hat - cat) !== 3) begin
      failures++;
      $display("FAIL conf_host_second: got rdata=%h gap=%0d exp %h gap 3", hrd, hat - cat, e);
    end
    checks++;
    if (conflict_cnt !== model_cnt[7:0]) begin
      failures++;
      $display("FAIL conf_cnt: got %0d exp %0d", conflict_cnt, model_cnt);
    end
  endtask

  task automatic test_cpu_rw();
    logic [15:0] rd, e;
    int at, lat, w0;
    bit tmo;
    w0 = we_cycles;
    cpu_exp_q.push_back(16'h1111);
    cpu_txn(1'b1, 12'h010, 16'h1234, rd, at, lat, tmo);
    e = cpu_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e || lat !== 3) begin
      failures++;
      $display("FAIL cpu_write: got rdata=%h lat=%0d tmo=%0d exp %h lat 3", rd, lat, tmo, e);
    end
    checks++;
    if ((we_cycles - w0) !== 1) begin
      failures++;
      $display("FAIL cpu_we_width: got %0d cycles exp 1", we_cycles - w0);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_pulse: got %b exp 0", cpu_ack);
    end
    @(posedge clk); #1;
    cpu_exp_q.push_back(16'h1234);
    cpu_exp_q.push_back(16'hBEEF);
    cpu_txn(1'b0, 12'h010, 16'h0, rd, at, lat, tmo);
    e = cpu_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e || lat !== 3) begin
      failures++;
      $display("FAIL cpu_read: got rdata=%h lat=%0d tmo=%0d exp %h lat 3", rd, lat, tmo, e);
    end
    cpu_txn(1'b0, 12'h100, 16'h0, rd, at, lat, tmo);
    e = cpu_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e || (we_cycles - w0) !== 1) begin
      failures++;
      $display("FAIL cpu_read_host_data: got %h we=%0d exp %h we 1", rd, we_cycles - w0, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, e;
    int at, lat, idx, w0, bad;
    bit tmo;
    host_exp_q.push_back(16'h5A5A);
    host_txn(1'b1, 12'h300, 16'h3333, rd, at, lat, tmo);
    e = host_exp_q.pop_front();
    checks++;
    if (tmo || rd !== e) begin
      failures++;
      $display("FAIL b2b_pre: got %h exp %h", rd, e);
    end
    idx = ack_log.size();
    w0 = we_cycles;
    cpu_exp_q.push_back(16'hBEEF); cpu_exp_q.push_back(16'h2222); cpu_exp_q.push_back(16'h1234);
    host_exp_q.push_back(16'h3333); host_exp_q.push_back(16'h3333); host_exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 6; i++) exp_order_q.push_back(i[0]);
    fork
      begin
        logic [15:0] c_rd, c_e;
        int c_at, c_lat;
        bit c_tmo;
        logic [11:0] adrs [3];
        logic        wes [3];
        adrs = '{12'h200, 12'h200, 12'h010};
        wes  = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
          cpu_txn(wes[k], adrs[k], 16'h2222, c_rd, c_at, c_lat, c_tmo);
          c_e = cpu_exp_q.pop_front();
          checks++;
          if (c_tmo || c_rd !== c_e) begin
            failures++;
            $display("FAIL b2b_cpu%0d: got %h tmo=%0d exp %h", k, c_rd, c_tmo, c_e);
          end
        end
      end
      begin
        logic [15:0] h_rd, h_e;
        int h_at, h_lat;
        bit h_tmo;
        logic [11:0] adrs [3];
        logic        wes [3];
        adrs = '{12'h300, 12'h301, 12'h100};
        wes  = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
          host_txn(wes[k], adrs[k], 16'h4444, h_rd, h_at, h_lat, h_tmo);
          h_e = host_exp_q.pop_front();
          checks++;
          if (h_tmo || h_rd !== h_e) begin
            failures++;
            $display("FAIL b2b_host%0d: got %h tmo=%0d exp %h", k, h_rd, h_tmo, h_e);
          end
        end
      end
    join
    model_cnt = model_cnt + 1;
    bad = 0;
    checks++;
    if ((ack_log.size() - idx) !== 6) begin
      failures++;
      $display("FAIL b2b_count: got %0d acks exp 6", ack_log.size() - idx);
    end else begin
      for (int i = 0; i < 6; i++) begin
        e[0] = exp_order_q.pop_front();
        if (ack_log[idx + i] !== e[0]) bad++;
        if (i > 0 && (ack_cyc_log[idx + i] - ack_cyc_log[idx + i - 1]) !== 3) bad++;
      end
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_order: got %0d order/spacing errors exp 0", bad);
      end
    end
    exp_order_q.delete();
    checks++;
    if ((we_cycles - w0) !== 2 || conflict_cnt !== model_cnt[7:0]) begin
      failures++;
      $display("FAIL b2b_we_cnt: got we=%0d cnt=%0d exp 2/%0d", we_cycles - w0, conflict_cnt, model_cnt);
    end
  endtask

  task automatic test_host_lock();
    logic [15:0] crd, hrd, e;
    int cat, clat, hat, hlat, idx, drop;
    bit ctmo, htmo;
    host_lock = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL lock_hold: got %b exp 1", cpu_hold);
    end
    idx = ack_log.size();
    drop = 0;
    cpu_exp_q.push_back(16'hABCD);
    host_exp_q.push_back(16'hBEEF);
    host_exp_q.push_back(16'hABCD);
    fork
      cpu_txn(1'b0, 12'hFFF, 16'h0, crd, cat, clat, ctmo);
      begin
        host_txn(1'b1, 12'hFFF, 16'hABCD, hrd, hat, hlat, htmo);
        e = host_exp_q.pop_front();
        checks++;
        if (htmo || hrd !== e) begin
          failures++;
          $display("FAIL lock_hwrite: got %h exp %h", hrd, e);
        end
        host_txn(1'b0, 12'hFFF, 16'h0, hrd, hat, hlat, htmo);
        e = host_exp_q.pop_front();
        checks++;
        if (htmo || hrd !== e) begin
          failures++;
          $display("FAIL lock_hread: got %h exp %h", hrd, e);
        end
        checks++;
        if ((ack_log.size() - idx) !== 2 || ack_log[ack_log.size() - 1] !== 1'b1) begin
          failures++;
          $display("FAIL lock_cpu_excluded: got %0d acks exp 2 host-only", ack_log.size() - idx);
        end
        host_lock = 1'b0;
        drop = cyc;
      end
    join
    e = cpu_exp_q.pop_front();
    checks++;
    if (ctmo || crd !== e || (cat - drop) !== 3) begin
      failures++;
      $display("FAIL lock_release: got rdata=%h delay=%0d tmo=%0d exp %h delay 3", crd, cat - drop, ctmo, e);
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL unlock_hold: got %b exp 0", cpu_hold);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] crd, hrd;
    int cat, clat, hat, hlat, tmos;
    bit ctmo, htmo;
    tmos = 0;
    for (int r = 0; r < 300; r++) begin
      fork
        cpu_txn(1'b0, 12'h010, 16'h0, crd, cat, clat, ctmo);
        host_txn(1'b0, 12'h300, 16'h0, hrd, hat, hlat, htmo);
      join
      if (ctmo || htmo) tmos++;
      model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
      if (r == 251 || r == 252) begin
        checks++;
        if (conflict_cnt !== model_cnt[7:0]) begin
          failures++;
          $display("FAIL sat_round%0d: got %0d exp %0d", r, conflict_cnt, model_cnt);
        end
      end
    end
    checks++;
    if (conflict_cnt !== 8'd255 || tmos != 0) begin
      failures++;
      $display("FAIL sat_final: got cnt=%0d timeouts=%0d exp 255/0", conflict_cnt, tmos);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_conflict();
    test_cpu_rw();
    test_back_to_back();
    test_host_lock();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
